// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU and long-latency results onto the register file write port
module wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        long_valid,
  input  logic [4:0]  long_rd,
  input  logic [31:0] long_data,
  output logic        long_ready,
  output logic        stall,
  output logic        err,
  output logic        w_enable,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic alu_eff;
  logic fifo_nonempty;
  logic push;
  logic pop;

  // x0 writes are architecturally invisible, so they are filtered before arbitration
  always_comb begin
    alu_eff       = alu_valid && (alu_rd != 5'd0);
    fifo_nonempty = (count != '0);
    long_ready    = (count < FULL);
    stall         = (starve_cnt == SMAX);
    push          = long_valid && long_ready && (long_rd != 5'd0);
    pop           = !alu_eff && fifo_nonempty;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= long_rd;
      data_mem[wr_ptr] <= long_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      err        <= 1'b0;
      w_enable   <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
    end else begin
      // An ALU result issued during stall still wins; only the flag records it
      if (alu_eff) begin
        w_enable <= 1'b1;
        w_addr   <= alu_rd;
        w_data   <= alu_data;
      end else if (pop) begin
        w_enable <= 1'b1;
        w_addr   <= rd_mem[rd_ptr];
        w_data   <= data_mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end else begin
        w_enable <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop || !fifo_nonempty) starve_cnt <= '0;
      else if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 1'b1;

      if (alu_eff && stall) err <= 1'b1;
    end
  end

endmodule
